vproc_xif_mem_responder: RTL and testbench

CPU-side responder for the coprocessor memory and memory-result channels of the XIF. Accepts memory requests issued by the vector unit, checks alignment, forwards legal requests to the host data bus (OBI-style req/gnt/rvalid), and returns read data and bus errors to the coprocessor in request order, tagged with the originating instruction id. Sits in the host-CPU wrapper between the XIF instance and the data-memory port.

---
 rtl/vproc_xif_pkg.sv | 13 +
 rtl/vproc_xif_if.sv | 46 ++++
 rtl/vproc_xif_id_fifo.sv | 60 ++++++
 rtl/vproc_xif_mem_responder.sv | 132 +++++++++++++
 tb/tb_vproc_xif_mem_responder.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vproc_xif_pkg.sv
// Shared constants and helpers for the XIF memory responder.
// Exception codes follow the RISC-V mcause encoding for misaligned accesses.
package vproc_xif_pkg;

    localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

    // Address bits that must be zero for an access of 2**size bytes.
    function automatic logic [31:0] align_mask(input logic [2:0] size);
        return (32'd1 << size) - 32'd1;
    endfunction

endpackage

// File: rtl/vproc_xif_if.sv
// XIF memory and memory-result channels between the vector unit and the host CPU.
// Only the fields the responder needs are modelled; widths follow the XIF instance.
interface vproc_xif #(
    parameter int unsigned X_ID_WIDTH  = 3,
    parameter int unsigned X_MEM_WIDTH = 32
);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]    id;
        logic [31:0]              addr;
        logic [1:0]               mode;
        logic                     we;
        logic [2:0]               size;
        logic [X_MEM_WIDTH/8-1:0] be;
        logic [1:0]               attr;
        logic [X_MEM_WIDTH-1:0]   wdata;
        logic                     last;
        logic                     spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
        logic                   dbg;
    } x_mem_result_t;

    logic          mem_valid;
    logic          mem_ready;
    x_mem_req_t    mem_req;
    x_mem_resp_t   mem_resp;
    logic          mem_result_valid;
    x_mem_result_t mem_result;

    modport cpu_mem (input mem_valid, mem_req, output mem_ready, mem_resp);
    modport coproc_mem (output mem_valid, mem_req, input mem_ready, mem_resp);
    modport cpu_mem_result (output mem_result_valid, mem_result);
    modport coproc_mem_result (input mem_result_valid, mem_result);

endinterface

// File: rtl/vproc_xif_id_fifo.sv
// Circular id FIFO; occupancy is tracked by the owner, which never pops when empty
// and only pushes when full if it pops in the same cycle.
module vproc_xif_id_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path can infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Full-with-pop reads the old head before the push overwrites anything.
    assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/vproc_xif_mem_responder.sv
// CPU-side responder for the XIF memory channels: alignment check, OBI-style bus
// drive, and in-order id-tagged results one cycle after each bus response.
module vproc_xif_mem_responder
    import vproc_xif_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH      = 3,
    parameter int unsigned X_MEM_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    vproc_xif.cpu_mem                xif_mem_if,
    vproc_xif.cpu_mem_result         xif_mem_result_if,
    output logic                     data_req_o,
    input  logic                     data_gnt_i,
    output logic [31:0]              data_addr_o,
    output logic                     data_we_o,
    output logic [X_MEM_WIDTH/8-1:0] data_be_o,
    output logic [X_MEM_WIDTH-1:0]   data_wdata_o,
    input  logic                     data_rvalid_i,
    input  logic [X_MEM_WIDTH-1:0]   data_rdata_i,
    input  logic                     data_err_i
);

    localparam int unsigned      BE_W      = X_MEM_WIDTH / 8;
    localparam int unsigned      LOG_BYTES = $clog2(BE_W);
    localparam int unsigned      CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0]       MAX_SIZE  = 3'(LOG_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      ADDR_MASK = ~(32'(BE_W) - 32'd1);

    logic                   exc;
    logic                   misaligned;
    logic                   slot_free;
    logic                   handshake;
    logic                   pop;
    logic [X_ID_WIDTH-1:0]  head_id;

    logic [CNT_W-1:0]       count_q, count_d;
    logic                   res_valid_q, res_valid_d;
    logic [X_ID_WIDTH-1:0]  res_id_q, res_id_d;
    logic [X_MEM_WIDTH-1:0] res_rdata_q, res_rdata_d;
    logic                   res_err_q, res_err_d;

    // Ordering and privilege hints are carried on the channel but not acted on here.
    logic unused_req_fields;
    assign unused_req_fields = ^{xif_mem_if.mem_req.mode, xif_mem_if.mem_req.attr,
                                 xif_mem_if.mem_req.last, xif_mem_if.mem_req.spec};

    assign misaligned = (xif_mem_if.mem_req.addr & align_mask(xif_mem_if.mem_req.size)) != 32'd0;
    assign exc        = (xif_mem_if.mem_req.size > MAX_SIZE) || misaligned;

    always_comb begin
        xif_mem_if.mem_resp.exc     = exc;
        xif_mem_if.mem_resp.exccode = 6'd0;
        xif_mem_if.mem_resp.dbg     = 1'b0;
        if (exc) begin
            xif_mem_if.mem_resp.exccode = xif_mem_if.mem_req.we ? EXC_STORE_MISALIGNED
                                                                : EXC_LOAD_MISALIGNED;
        end
    end

    // A response in the same cycle frees a slot, so a full pipe can still take a grant.
    assign slot_free  = (count_q < CNT_MAX) || data_rvalid_i;
    assign data_req_o = xif_mem_if.mem_valid && !exc && slot_free;
    assign handshake  = data_req_o && data_gnt_i;
    assign pop        = data_rvalid_i && (count_q != '0);

    assign xif_mem_if.mem_ready = (xif_mem_if.mem_valid && exc) || handshake;

    assign data_addr_o  = xif_mem_if.mem_req.addr & ADDR_MASK;
    assign data_we_o    = xif_mem_if.mem_req.we;
    assign data_be_o    = xif_mem_if.mem_req.be;
    assign data_wdata_o = xif_mem_if.mem_req.wdata;

    vproc_xif_id_fifo #(
        .WIDTH (X_ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (handshake),
        .push_data_i (xif_mem_if.mem_req.id),
        .pop_i       (pop),
        .pop_data_o  (head_id)
    );

    always_comb begin
        count_d = count_q;
        case ({handshake, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Result fields hold their last value between pulses; only the valid bit is a pulse.
    always_comb begin
        res_valid_d = pop;
        res_id_d    = res_id_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        if (pop) begin
            res_id_d    = head_id;
            res_rdata_d = data_rdata_i;
            res_err_d   = data_err_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
        end
    end

    assign xif_mem_result_if.mem_result_valid = res_valid_q;
    assign xif_mem_result_if.mem_result.id    = res_id_q;
    assign xif_mem_result_if.mem_result.rdata = res_rdata_q;
    assign xif_mem_result_if.mem_result.err   = res_err_q;
    assign xif_mem_result_if.mem_result.dbg   = 1'b0;

endmodule

// File: tb/tb_vproc_xif_mem_responder.sv
// Bench for vproc_xif_mem_responder: directed scenarios plus random traffic checked
// against a queue-based model of outstanding ids and a one-cycle result expectation.
module tb_vproc_xif_mem_responder;

    localparam int unsigned ID_W    = 3;
    localparam int unsigned MEM_W   = 32;
    localparam int unsigned MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_req;
    logic        data_gnt = 1'b0;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic        data_err = 1'b0;

    always #5 clk = ~clk;

    vproc_xif #(.X_ID_WIDTH(ID_W), .X_MEM_WIDTH(MEM_W)) xif ();

    vproc_xif_mem_responder #(
        .X_ID_WIDTH      (ID_W),
        .X_MEM_WIDTH     (MEM_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .xif_mem_if        (xif),
        .xif_mem_result_if (xif),
        .data_req_o        (data_req),
        .data_gnt_i        (data_gnt),
        .data_addr_o       (data_addr),
        .data_we_o         (data_we),
        .data_be_o         (data_be),
        .data_wdata_o      (data_wdata),
        .data_rvalid_i     (data_rvalid),
        .data_rdata_i      (data_rdata),
        .data_err_i        (data_err)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: ids granted but not yet answered, and the result due next cycle.
    int unsigned out_q[$];
    int          occ;
    bit          exp_v = 1'b0;
    logic [2:0]  exp_id;
    logic [31:0] exp_rdata;
    bit          exp_err;

    function automatic bit model_exc(input logic [31:0] addr, input logic [2:0] size);
        int unsigned nbytes;
        nbytes = 1 << size;
        return (size > 3'd2) || ((addr % nbytes) != 0);
    endfunction

    function automatic logic [5:0] model_code(input bit exc, input bit we);
        if (!exc) return 6'd0;
        return we ? 6'd6 : 6'd4;
    endfunction

    always @(posedge clk) begin
        if (!rst_ni) begin
            out_q.delete();
            exp_v = 1'b0;
        end else begin
            occ   = out_q.size();
            exp_v = 1'b0;
            if (data_rvalid && occ > 0) begin
                exp_v     = 1'b1;
                exp_id    = 3'(out_q.pop_front());
                exp_rdata = data_rdata;
                exp_err   = data_err;
            end
            if (xif.mem_valid && !model_exc(xif.mem_req.addr, xif.mem_req.size) && data_gnt &&
                (occ < int'(MAX_OUT) || data_rvalid))
                out_q.push_back(int'(xif.mem_req.id));
        end
    end

    // Every cycle: the result channel must pulse exactly when the model says so.
    always @(negedge clk) begin
        compared++;
        if (xif.mem_result_valid !== exp_v) begin
            mismatched++;
            $display("FAIL result_valid @%0t: got %b expected %b", $time, xif.mem_result_valid, exp_v);
        end else if (exp_v) begin
            compared++;
            if ({xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err, xif.mem_result.dbg} !==
                {exp_id, exp_rdata, exp_err, 1'b0}) begin
                mismatched++;
                $display("FAIL result_fields @%0t: got id=%0d rdata=%h err=%b dbg=%b expected id=%0d rdata=%h err=%b dbg=0",
                         $time, xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err,
                         xif.mem_result.dbg, exp_id, exp_rdata, exp_err);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input bit v, input logic [31:0] a, input logic [2:0] s,
                           input bit w, input logic [2:0] i);
        xif.mem_valid      = v;
        xif.mem_req.addr   = a;
        xif.mem_req.size   = s;
        xif.mem_req.we     = w;
        xif.mem_req.id     = i;
        xif.mem_req.be     = 4'($urandom);
        xif.mem_req.wdata  = $urandom;
        xif.mem_req.mode   = 2'($urandom);
        xif.mem_req.attr   = 2'($urandom);
        xif.mem_req.last   = 1'($urandom);
        xif.mem_req.spec   = 1'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        compared++;
        if ({data_req, xif.mem_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_req_ready: got %b expected 00", {data_req, xif.mem_ready});
        end
        compared++;
        if ({xif.mem_result_valid, xif.mem_result} !== '0) begin
            mismatched++;
            $display("FAIL reset_result: got valid=%b result=%h expected all zero",
                     xif.mem_result_valid, xif.mem_result);
        end
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_word_load();
        set_req(1'b1, 32'h100, 3'd2, 1'b0, 3'd5);
        data_gnt = 1'b1;
        #1;
        compared++;
        if ({data_req, xif.mem_ready, xif.mem_resp.exc, xif.mem_resp.exccode} !== {1'b1, 1'b1, 1'b0, 6'd0}) begin
            mismatched++;
            $display("FAIL word_load_accept: got req=%b ready=%b exc=%b code=%0d expected 1 1 0 0",
                     data_req, xif.mem_ready, xif.mem_resp.exc, xif.mem_resp.exccode);
        end
        compared++;
        if ({data_addr, data_we, data_be, data_wdata} !==
            {32'h100, 1'b0, xif.mem_req.be, xif.mem_req.wdata}) begin
            mismatched++;
            $display("FAIL word_load_bus: got addr=%h we=%b be=%h wdata=%h expected addr=00000100 we=0 be=%h wdata=%h",
                     data_addr, data_we, data_be, data_wdata, xif.mem_req.be, xif.mem_req.wdata);
        end
        next_cycle();
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        next_cycle();
        next_cycle();
        data_rvalid = 1'b1;
        data_rdata  = 32'hDEADBEEF;
        next_cycle();
        data_rvalid = 1'b0;
        #1;
        compared++;
        if ({xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err} !==
            {1'b1, 3'd5, 32'hDEADBEEF, 1'b0}) begin
            mismatched++;
            $display("FAIL word_load_result: got v=%b id=%0d rdata=%h err=%b expected 1 5 deadbeef 0",
                     xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata, xif.mem_result.err);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h103, 32'h108, 32'h108};
        logic [2:0]  sizes [3] = '{3'd1, 3'd3, 3'd3};
        bit          wes   [3] = '{1'b1, 1'b0, 1'b1};
        logic [5:0]  codes [3] = '{6'd6, 6'd4, 6'd6};
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, addrs[k], sizes[k], wes[k], 3'(k + 1));
            data_gnt = 1'b1;
            #1;
            compared++;
            if ({xif.mem_ready, data_req, xif.mem_resp.exc, xif.mem_resp.exccode, xif.mem_resp.dbg} !==
                {1'b1, 1'b0, 1'b1, codes[k], 1'b0}) begin
                mismatched++;
                $display("FAIL misaligned_%0d: got ready=%b req=%b exc=%b code=%0d dbg=%b expected 1 0 1 %0d 0",
                         k, xif.mem_ready, data_req, xif.mem_resp.exc, xif.mem_resp.exccode,
                         xif.mem_resp.dbg, codes[k]);
            end
            next_cycle();
        end
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_exception_check();
        logic [31:0] a;
        logic [2:0]  s;
        bit          w, e, er;
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            s = 3'($urandom_range(0, 7));
            w = 1'($urandom);
            if (k % 2 == 0) a = a & ~((32'd1 << s) - 32'd1);
            set_req(1'b1, a, s, w, 3'($urandom));
            data_gnt = 1'b0;
            #1;
            e  = model_exc(a, s);
            er = !e && (out_q.size() < MAX_OUT);
            compared++;
            if ({xif.mem_resp.exc, xif.mem_resp.exccode, xif.mem_ready, data_req} !==
                {e, model_code(e, w), e, er}) begin
                mismatched++;
                $display("FAIL exc_check addr=%h size=%0d we=%b: got exc=%b code=%0d ready=%b req=%b expected %b %0d %b %b",
                         a, s, w, xif.mem_resp.exc, xif.mem_resp.exccode, xif.mem_ready, data_req,
                         e, model_code(e, w), e, er);
            end
            if (er) begin
                compared++;
                if ({data_addr, data_we} !== {a & 32'hFFFF_FFFC, w}) begin
                    mismatched++;
                    $display("FAIL bus_addr: got addr=%h we=%b expected %h %b",
                             data_addr, data_we, a & 32'hFFFF_FFFC, w);
                end
            end
            next_cycle();
        end
        xif.mem_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
        data_gnt = 1'b1;
        set_req(1'b1, 32'h200, 3'd2, 1'b0, 3'd1);
        #1;
        compared++;
        if (xif.mem_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_first_ready: got %b expected 1", xif.mem_ready);
        end
        next_cycle();
        set_req(1'b1, 32'h204, 3'd2, 1'b0, 3'd2);
        #1;
        compared++;
        if (xif.mem_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second_ready: got %b expected 1", xif.mem_ready);
        end
        next_cycle();
        set_req(1'b1, 32'h208, 3'd2, 1'b0, 3'd3);
        #1;
        compared++;
        if ({data_req, xif.mem_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_full_stall: got req=%b ready=%b expected 0 0", data_req, xif.mem_ready);
        end
        next_cycle();
        data_rvalid = 1'b1;
        data_rdata  = rd[0];
        #1;
        compared++;
        if ({data_req, xif.mem_ready} !== 2'b11) begin
            mismatched++;
            $display("FAIL b2b_full_with_rvalid: got req=%b ready=%b expected 1 1", data_req, xif.mem_ready);
        end
        next_cycle();
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_rvalid = (k < 2);
            data_rdata  = (k < 2) ? rd[k+1] : 32'd0;
            #1;
            compared++;
            if ({xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata} !==
                {1'b1, 3'(k + 1), rd[k]}) begin
                mismatched++;
                $display("FAIL b2b_order_%0d: got v=%b id=%0d rdata=%h expected 1 %0d %h",
                         k, xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata, k + 1, rd[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_error_response();
        set_req(1'b1, 32'h300, 3'd2, 1'b0, 3'd6);
        data_gnt = 1'b1;
        next_cycle();
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        data_rvalid   = 1'b1;
        data_err      = 1'b1;
        data_rdata    = $urandom;
        next_cycle();
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        #1;
        compared++;
        if ({xif.mem_result_valid, xif.mem_result.id, xif.mem_result.err} !== {1'b1, 3'd6, 1'b1}) begin
            mismatched++;
            $display("FAIL err_result: got v=%b id=%0d err=%b expected 1 6 1",
                     xif.mem_result_valid, xif.mem_result.id, xif.mem_result.err);
        end
        // Stray response with nothing outstanding, then two grants to prove the count is back at 0.
        data_rvalid = 1'b1;
        next_cycle();
        data_rvalid = 1'b0;
        data_gnt    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_req(1'b1, 32'h400 + 32'(4 * k), 3'd2, 1'b0, 3'(k * 7));
            #1;
            compared++;
            if (xif.mem_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL err_count_cleared_%0d: got ready=%b expected 1", k, xif.mem_ready);
            end
            next_cycle();
        end
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        data_rvalid   = 1'b1;
        data_rdata    = $urandom;
        next_cycle();
        data_rdata = $urandom;
        next_cycle();
        data_rvalid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        data_gnt = 1'b1;
        set_req(1'b1, 32'h500, 3'd2, 1'b0, 3'd2);
        next_cycle();
        set_req(1'b1, 32'h504, 3'd2, 1'b0, 3'd3);
        next_cycle();
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        #2;
        rst_ni = 1'b0;
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        data_rvalid = 1'b1;
        data_rdata  = 32'h5555_5555;
        next_cycle();
        data_rvalid = 1'b0;
        #1;
        compared++;
        if (xif.mem_result_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_drops_late_rvalid: got v=%b expected 0", xif.mem_result_valid);
        end
        set_req(1'b1, 32'h600, 3'd2, 1'b0, 3'd4);
        data_gnt = 1'b1;
        next_cycle();
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        data_rvalid   = 1'b1;
        data_rdata    = 32'h0000_1234;
        next_cycle();
        data_rvalid = 1'b0;
        #1;
        compared++;
        if ({xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata} !== {1'b1, 3'd4, 32'h0000_1234}) begin
            mismatched++;
            $display("FAIL reset_then_load: got v=%b id=%0d rdata=%h expected 1 4 00001234",
                     xif.mem_result_valid, xif.mem_result.id, xif.mem_result.rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  s;
        bit          v, e, er, erdy;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
            set_req(v, a, s, 1'($urandom), 3'($urandom));
            data_gnt    = ($urandom_range(0, 3) != 0);
            data_rvalid = (out_q.size() > 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            data_rdata  = $urandom;
            data_err    = ($urandom_range(0, 5) == 0);
            #1;
            e    = model_exc(a, s);
            er   = v && !e && (out_q.size() < MAX_OUT || data_rvalid);
            erdy = v && (e || (er && data_gnt));
            compared++;
            if ({data_req, xif.mem_ready, xif.mem_resp.exc, xif.mem_resp.exccode} !==
                {er, erdy, e, model_code(e, xif.mem_req.we)}) begin
                mismatched++;
                $display("FAIL random_%0d: got req=%b ready=%b exc=%b code=%0d expected %b %b %b %0d",
                         k, data_req, xif.mem_ready, xif.mem_resp.exc, xif.mem_resp.exccode,
                         er, erdy, e, model_code(e, xif.mem_req.we));
            end
            next_cycle();
        end
        xif.mem_valid = 1'b0;
        data_gnt      = 1'b0;
        for (int k = 0; k <= int'(MAX_OUT); k++) begin
            data_rvalid = 1'b1;
            data_rdata  = $urandom;
            next_cycle();
        end
        data_rvalid = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        xif.mem_valid = 1'b0;
        xif.mem_req   = '0;
        test_reset();
        test_word_load();
        test_misaligned();
        test_exception_check();
        test_back_to_back();
        test_error_response();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
